// File: rtl/ball_pad_ctl.sv
// ball_pad_ctl: per-frame pong physics stage.
// Once per frame, at the onset of vertical blank, this block does the following:
//   - advances the ball and bounces it off the walls and the pads,
//   - detects misses and keeps the score,
//   - moves both pads from the player buttons.
// All coordinates are registered and change only on that frame tick.
//
// Optional feature: define BALL_SPEEDUP_EN to make each pad hit raise the ball
// speed by one (saturating at 8). The speed returns to BALL_SPEED on every serve.
//
// Ports:
//   clk, rst_n                      pixel clock, async active-low reset
//   vblnk                           vertical blank from the timing generator
//   start                           one-cycle pulse, starts a game from IDLE/OVER
//   btn_l_up/dn, btn_r_up/dn        debounced level buttons
//   x_ball, y_ball                  ball top-left corner (16x16 box)
//   y_pad_left, y_pad_right         pad top edges (146 px tall)
//   score_left, score_right         current scores
//   point_l, point_r                one-cycle pulse when that player scores
//   game_over                       high while the game is over
module ball_pad_ctl #(
    parameter int unsigned BALL_SPEED   = 2,
    parameter int unsigned PAD_SPEED    = 4,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblnk,
    input  logic       start,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    output logic [9:0] x_ball,
    output logic [9:0] y_ball,
    output logic [9:0] y_pad_left,
    output logic [9:0] y_pad_right,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       point_l,
    output logic       point_r,
    output logic       game_over
);

    localparam int unsigned POS_W = 11;
    localparam int unsigned CNT_W = 16;
    typedef logic signed [POS_W-1:0] pos_t;

    localparam pos_t BALL_X_MID = 11'sd504;
    localparam pos_t BALL_Y_MID = 11'sd376;
    localparam pos_t BALL_X_MAX = 11'sd1008;
    localparam pos_t BALL_Y_MAX = 11'sd752;
    localparam pos_t BALL_S_M1  = 11'sd15;
    localparam pos_t PAD_MID    = 11'sd311;
    localparam pos_t PAD_MAX    = 11'sd622;
    localparam pos_t PAD_H_M1   = 11'sd145;
    localparam pos_t L_FACE     = 11'sd46;   // ball x resting against left pad
    localparam pos_t R_FACE     = 11'sd963;  // ball x resting against right pad
    localparam pos_t PAD_STEP   = POS_W'(PAD_SPEED);

    typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

    state_t           state_q, state_d;
    logic             vblnk_q, tick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pos_t             x_q, x_d, y_q, y_d, pl_q, pl_d, pr_q, pr_d;
    logic             dxr_q, dxr_d, dyd_q, dyd_d;
    logic [3:0]       sl_q, sl_d, sr_q, sr_d;
    logic             ptl_d, ptr_d, go_d;
    pos_t             spd, py;
    logic             pdyd, ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;
    logic             serve_done, point_done, win, serving;

    // One tick per frame: rising edge of vblnk.
    assign tick = vblnk & ~vblnk_q;

    // Clamped single-step pad motion; both or neither button holds.
    function automatic pos_t pad_move(input pos_t y, input logic up, input logic dn);
        pos_t r;
        r = y;
        if (up && !dn) begin
            r = (y < PAD_STEP) ? '0 : y - PAD_STEP;
        end else if (dn && !up) begin
            r = (y + PAD_STEP > PAD_MAX) ? PAD_MAX : y + PAD_STEP;
        end
        return r;
    endfunction

`ifdef BALL_SPEEDUP_EN
    logic [3:0] speed_q, speed_d;

    assign spd = POS_W'(speed_q);

    // Speed rises on each pad hit and is reloaded on serve.
    always_comb begin
        speed_d = speed_q;
        if (tick && state_q == S_PLAY && (hit_l || hit_r)) begin
            speed_d = (speed_q >= 4'd8) ? 4'd8 : speed_q + 4'd1;
        end
        if (serving) begin
            speed_d = 4'(BALL_SPEED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_q <= 4'(BALL_SPEED);
        end else begin
            speed_q <= speed_d;
        end
    end
`else
    assign spd = POS_W'(BALL_SPEED);
`endif

    // Vertical move with wall bounce.
    always_comb begin
        py   = y_q;
        pdyd = dyd_q;
        if (!dyd_q) begin
            if (y_q < spd) begin
                py   = '0;
                pdyd = 1'b1;
            end else begin
                py = y_q - spd;
            end
        end else begin
            if (y_q + spd >= BALL_Y_MAX) begin
                py   = BALL_Y_MAX;
                pdyd = 1'b0;
            end else begin
                py = y_q + spd;
            end
        end
    end

    // Pad contact and miss detection use the pre-move ball and pad positions.
    assign ovl_l  = (y_q + BALL_S_M1 >= pl_q) && (y_q <= pl_q + PAD_H_M1);
    assign ovl_r  = (y_q + BALL_S_M1 >= pr_q) && (y_q <= pr_q + PAD_H_M1);
    assign hit_l  = !dxr_q && (x_q >= L_FACE) && (x_q - spd < L_FACE) && ovl_l;
    assign hit_r  = dxr_q && (x_q <= R_FACE) && (x_q + spd > R_FACE) && ovl_r;
    assign miss_l = !dxr_q && !hit_l && (x_q < spd);
    assign miss_r = dxr_q && !hit_r && (x_q + spd > BALL_X_MAX);

    assign serve_done = (32'(cnt_q) + 32'd1) >= SERVE_FRAMES;
    assign point_done = (32'(cnt_q) + 32'd1) >= POINT_FRAMES;
    assign win        = (sl_q == 4'(WIN_SCORE)) || (sr_q == 4'(WIN_SCORE));
    assign serving    = (state_d == S_SERVE) && (state_q != S_SERVE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_OVER: if (start) state_d = S_SERVE;
            S_SERVE:        if (tick && serve_done) state_d = S_PLAY;
            S_PLAY:         if (tick && (miss_l || miss_r)) state_d = S_POINT;
            S_POINT:        if (tick && point_done) state_d = win ? S_OVER : S_SERVE;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath/output next values.
    always_comb begin
        cnt_d = cnt_q;
        x_d   = x_q;
        y_d   = y_q;
        pl_d  = pl_q;
        pr_d  = pr_q;
        dxr_d = dxr_q;
        dyd_d = dyd_q;
        sl_d  = sl_q;
        sr_d  = sr_q;
        ptl_d = 1'b0;
        ptr_d = 1'b0;
        go_d  = (state_d == S_OVER);

        if (tick && (state_q == S_SERVE || state_q == S_PLAY || state_q == S_POINT)) begin
            pl_d = pad_move(pl_q, btn_l_up, btn_l_dn);
            pr_d = pad_move(pr_q, btn_r_up, btn_r_dn);
        end

        if (tick && state_q == S_PLAY) begin
            y_d   = py;
            dyd_d = pdyd;
            if (hit_l) begin
                x_d   = L_FACE;
                dxr_d = 1'b1;
            end else if (hit_r) begin
                x_d   = R_FACE;
                dxr_d = 1'b0;
            end else if (miss_l) begin
                sr_d  = sr_q + 4'd1;
                ptr_d = 1'b1;
            end else if (miss_r) begin
                sl_d  = sl_q + 4'd1;
                ptl_d = 1'b1;
            end else begin
                x_d = dxr_q ? x_q + spd : x_q - spd;
            end
        end

        if (tick && (state_q == S_SERVE || state_q == S_POINT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // dx is kept on serve so the ball heads toward whoever conceded.
        if (serving) begin
            x_d   = BALL_X_MID;
            y_d   = BALL_Y_MID;
            dyd_d = 1'b1;
        end
        if (serving && (state_q == S_IDLE || state_q == S_OVER)) begin
            sl_d = '0;
            sr_d = '0;
            pl_d = PAD_MID;
            pr_d = PAD_MID;
        end
    end

    // Datapath registers; vblnk_q resets high so a high vblnk at release is not a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q   <= 1'b1;
            cnt_q     <= '0;
            x_q       <= BALL_X_MID;
            y_q       <= BALL_Y_MID;
            pl_q      <= PAD_MID;
            pr_q      <= PAD_MID;
            dxr_q     <= 1'b1;
            dyd_q     <= 1'b1;
            sl_q      <= '0;
            sr_q      <= '0;
            point_l   <= 1'b0;
            point_r   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            vblnk_q   <= vblnk;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pl_q      <= pl_d;
            pr_q      <= pr_d;
            dxr_q     <= dxr_d;
            dyd_q     <= dyd_d;
            sl_q      <= sl_d;
            sr_q      <= sr_d;
            point_l   <= ptl_d;
            point_r   <= ptr_d;
            game_over <= go_d;
        end
    end

    assign x_ball      = x_q[9:0];
    assign y_ball      = y_q[9:0];
    assign y_pad_left  = pl_q[9:0];
    assign y_pad_right = pr_q[9:0];
    assign score_left  = sl_q;
    assign score_right = sr_q;

endmodule

// File: doc/ball_pad_ctl.md
# ball_pad_ctl

Per-frame game-physics stage for the pong datapath. Once per video frame it advances the ball, bounces it off the top and bottom walls and the two pads, detects misses, keeps score, and moves the pads from player buttons. Its registered ball and pad coordinates feed the ball/pad drawing stage directly. Updates happen only at vertical-blank onset, so coordinates never change during active video.

## Interface
Parameters:
- BALL_SPEED, 2: initial ball step per frame on each axis, in px (1..8).
- PAD_SPEED, 4: pad step per frame, in px.
- SERVE_FRAMES, 60: frames the ball is held at centre before a serve.
- POINT_FRAMES, 90: frames the ball is frozen after a miss.
- WIN_SCORE, 9: score that ends the game (1..15).

Ports:
- clk  in  1  pixel clock (65 MHz domain of the VGA chain).
- rst_n  in  1  asynchronous, active-low reset.
- vblnk  in  1  vertical blank from the timing generator.
- start  in  1  one-cycle pulse; starts a game from IDLE or OVER.
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  debounced level button inputs.
- x_ball, y_ball  out  10 each  ball top-left corner; the box is 16×16.
- y_pad_left, y_pad_right  out  10 each  pad top edges; each pad is 146 px tall.
- score_left, score_right  out  4 each  current scores.
- point_l, point_r  out  1 each  one-cycle pulse when the named player scores.
- game_over  out  1  high in state OVER.

## Operation
- Field: x 0..1023, y 0..767.
  - Ball x range 0..1008; ball y range 0..752.
  - Pad y range 0..622.
  - Left pad occupies x 30..45. Right pad occupies x 979..994.
- Frame tick: vblnk_q is a register copy of vblnk. tick = vblnk & ~vblnk_q. All state below changes only on a tick.
- All position arithmetic is 11-bit signed. Results are clamped, never wrapped.
- Pads (every state except IDLE and OVER):
  - Up only: y -= PAD_SPEED, clamped at 0.
  - Down only: y += PAD_SPEED, clamped at 622.
  - Both buttons or neither: hold.
- FSM states: IDLE, SERVE, PLAY, POINT, OVER.
  - IDLE (reset state): ball at (504,376); pads at 311; scores 0. start → SERVE.
  - SERVE: ball held at (504,376). After SERVE_FRAMES ticks → PLAY.
    - Serve direction: dx toward the player who conceded the last point (right after reset); dy = down.
    - The ball speed is loaded with BALL_SPEED.
  - PLAY, evaluated per tick with s = speed:
    - Wall moving up: if y < s, then y = 0 and dy flips. Otherwise y -= s.
    - Wall moving down: if y + s ≥ 752, then y = 752 and dy flips. Otherwise y += s.
    - Vertical overlap test for pad hits uses the pre-move y: y+15 ≥ y_pad and y ≤ y_pad+145.
    - Left pad: dx = left, x ≥ 46, x−s ≤ 45, and overlap → x = 46, dx = right.
    - Right pad: dx = right, x ≤ 963, x+s ≥ 964, and overlap → x = 963, dx = left.
    - Miss: no pad hit and (x < s while moving left, or x+s > 1008 while moving right). The opponent's score increments, its point_* pulses, and the state goes to POINT.
    - Otherwise x moves by s.
    - A wall bounce and a pad bounce in the same tick are both applied.
  - POINT: ball frozen. After POINT_FRAMES ticks:
    - → OVER if either score equals WIN_SCORE.
    - Else → SERVE, with the ball re-centred.
  - OVER: game_over = 1, everything frozen. start → scores cleared, pads and ball centred, → SERVE.
- start is ignored in SERVE, PLAY and POINT.

## Timing
- Reset values: x_ball 504, y_ball 376, both pads 311, scores 0, point_l/point_r 0, game_over 0, state IDLE, frame counter 0.
- Latency: on the clk edge ending the first cycle in which vblnk is high, all outputs update. New values are visible one cycle after vblnk rises and stay stable until the next tick.
- point_* is high for exactly the one cycle following the tick edge.
- score_* changes on the same edge that point_* rises.
- The frame counter counts ticks only. SERVE_FRAMES = N means the ball leaves centre on the (N+1)th tick after entering SERVE.
- rst_n deassertion mid-frame: no tick is generated until vblnk next rises from 0. vblnk_q resets to 1 so a high vblnk at release does not tick.

## Configuration
- BALL_SPEEDUP_EN defined:
  - Each pad hit increments speed by 1, saturating at 8.
  - Speed returns to BALL_SPEED on every serve.
  - Speed is held in a 4-bit register.
- BALL_SPEEDUP_EN undefined: speed is constant BALL_SPEED and the register is removed.

## Test plan
- Reset, start, SERVE_FRAMES=2: ball is held at (504,376) for 2 ticks. 3rd tick → x 506, y 378.
- btn_l_up held 100 frames from y 311 → y_pad_left reaches 0 after 78 ticks and stays 0. Both buttons held → no change.
- Ball at (500,751), moving down, s=2 → y 752 with dy flipped. Next tick y 750.
- Ball x 47 moving left, s=2, y_ball 300, y_pad_left 200 → x 46, dx right, no point. Repeat with y_pad_left 400 → ball keeps moving; at x < 2 point_r pulses once, score_right 0→1, state POINT.
- score_left at WIN_SCORE−1 and the right player misses → after POINT_FRAMES ticks game_over=1. start → scores 0, SERVE.
- With BALL_SPEEDUP_EN: 3 consecutive pad hits from s=2 → s=5. After the next serve s=2.
